// File: rtl/beep_pkg.sv
// Shared types and helpers for the beep sequencer.
//   state_e    : FSM encoding (idle, tone on, silent gap)
//   BCD_TIME_W : width of a BCD {hh,mm,ss} time value
//   max1()     : beep count with 0 mapped to 1
package beep_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOn   = 2'b01,
    StGap  = 2'b10
  } state_e;

  localparam int unsigned BCD_TIME_W = 24;

  function automatic int unsigned max1(input int unsigned count);
    return (count == 0) ? 1 : count;
  endfunction

endpackage

// File: rtl/beep_sequencer_if.sv
// Control/status bundle between the key/RTC front end and the beep sequencer.
//   master : drives trig, cancel, alarm setup, rtc_time, burst and tone settings;
//            observes busy, alarm_hit, buzzer_n
//   slave  : the sequencer side (mirror of master)
interface beep_sequencer_if
  import beep_pkg::*;
#(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned PHASE_W = 32
) ();

  logic                  trig;
  logic                  cancel;
  logic                  alarm_en;
  logic [BCD_TIME_W-1:0] alarm_time;
  logic [BCD_TIME_W-1:0] rtc_time;
  logic [CNT_W-1:0]      beep_count;
  logic [PHASE_W-1:0]    tone_step;
  logic [PHASE_W-1:0]    duty;
  logic                  busy;
  logic                  alarm_hit;
  logic                  buzzer_n;

  modport master (
    output trig, cancel, alarm_en, alarm_time, rtc_time, beep_count, tone_step, duty,
    input  busy, alarm_hit, buzzer_n
  );

  modport slave (
    input  trig, cancel, alarm_en, alarm_time, rtc_time, beep_count, tone_step, duty,
    output busy, alarm_hit, buzzer_n
  );

endinterface

// File: rtl/beep_sequencer_tone_nco.sv
// NCO tone generator: phase accumulator with duty compare.
//   clk, rst_n : clock, async active-low reset
//   run        : advance phase by step this cycle
//   clr        : zero the phase (wins over run)
//   step, duty : phase increment and high threshold
//   pwm        : high while phase < duty
module tone_nco #(
  parameter int unsigned PHASE_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               clr,
  input  logic [PHASE_W-1:0] step,
  input  logic [PHASE_W-1:0] duty,
  output logic               pwm
);

  logic [PHASE_W-1:0] phase_d, phase_q;

  always_comb begin
    phase_d = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (run) begin
      phase_d = phase_q + step; // natural modulo-2^PHASE_W wrap
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end

  assign pwm = (phase_q < duty);

endmodule

// File: rtl/beep_sequencer.sv
// Buzzer burst controller: plays max(beep_count,1) tone beeps separated by
// silent gaps, started by trig or by a rising alarm match of the RTC time.
//   clk, rst_n : clock, async active-low reset
//   bus        : beep_sequencer_if.slave (trig/cancel/alarm/tone in; busy,
//                alarm_hit, buzzer_n out)
// Optional: define BEEP_SWEEP_EN to raise the pitch ~12.5 % on every beep.
module beep_sequencer
  import beep_pkg::*;
#(
  parameter int unsigned PHASE_W    = 32,
  parameter int unsigned ON_CYCLES  = 12_500_000,
  parameter int unsigned GAP_CYCLES = 5_000_000,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned TIMER_W    = 32
) (
  input logic              clk,
  input logic              rst_n,
  beep_sequencer_if.slave  bus
);

  localparam logic [TIMER_W-1:0] OnLast  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GapLast = TIMER_W'(GAP_CYCLES - 1);

  state_e             state_d, state_q;
  logic [TIMER_W-1:0] timer_d, timer_q;
  logic [CNT_W-1:0]   beeps_left_d, beeps_left_q;
  logic               match, match_q, alarm_hit_q;
  logic               start, start_burst, next_beep;
  logic [PHASE_W-1:0] nco_step;
  logic               pwm;

  // Edge detect so a match held for a whole RTC second fires once.
  assign match = bus.alarm_en & (bus.rtc_time == bus.alarm_time);
  assign start = bus.trig | alarm_hit_q;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    beeps_left_d = beeps_left_q;
    start_burst  = 1'b0;
    next_beep    = 1'b0;
    if (bus.cancel) begin
      state_d      = StIdle;
      timer_d      = '0;
      beeps_left_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            start_burst  = 1'b1;
            state_d      = StOn;
            timer_d      = '0;
            beeps_left_d = CNT_W'(max1(32'(bus.beep_count)) - 1);
          end
        end
        StOn: begin
          if (timer_q == OnLast) begin
            timer_d = '0;
            state_d = (beeps_left_q == '0) ? StIdle : StGap;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        StGap: begin
          if (timer_q == GapLast) begin
            next_beep    = 1'b1;
            timer_d      = '0;
            beeps_left_d = beeps_left_q - CNT_W'(1);
            state_d      = StOn;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      beeps_left_q <= '0;
      match_q      <= 1'b0;
      alarm_hit_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      beeps_left_q <= beeps_left_d;
      match_q      <= match;
      alarm_hit_q  <= match & ~match_q;
    end
  end

`ifdef BEEP_SWEEP_EN
  logic [PHASE_W-1:0] step_d, step_q;
  logic [PHASE_W:0]   step_sum;

  assign step_sum = {1'b0, step_q} + {1'b0, (step_q >> 3)};

  always_comb begin
    step_d = step_q;
    if (start_burst) begin
      step_d = bus.tone_step;
    end else if (next_beep) begin
      step_d = step_sum[PHASE_W] ? '1 : step_sum[PHASE_W-1:0]; // saturate
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= '0;
    else        step_q <= step_d;
  end

  assign nco_step = step_q;
`else
  assign nco_step = bus.tone_step;
`endif

  tone_nco #(
    .PHASE_W (PHASE_W)
  ) u_tone_nco (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state_q == StOn),
    .clr   (start_burst | next_beep),
    .step  (nco_step),
    .duty  (bus.duty),
    .pwm   (pwm)
  );

  assign bus.busy      = (state_q != StIdle);
  assign bus.alarm_hit = alarm_hit_q;
  assign bus.buzzer_n  = ~((state_q == StOn) & pwm);

endmodule

// File: tb/tb_beep_sequencer.sv
// Randomized plus directed bench for beep_sequencer with ON=10, GAP=5, PHASE_W=8.
// The reference model tracks only "cycles since burst start" and derives the
// expected outputs arithmetically from that position.
module tb_beep_sequencer;

  localparam int unsigned OnC  = 10;
  localparam int unsigned GapC = 5;
  localparam int unsigned Per  = OnC + GapC;

  logic clk;
  logic rst_n;

  beep_sequencer_if #(.CNT_W(4), .PHASE_W(8)) bus ();

  beep_sequencer #(
    .PHASE_W    (8),
    .ON_CYCLES  (OnC),
    .GAP_CYCLES (GapC),
    .CNT_W      (4),
    .TIMER_W    (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // model state
  bit          m_active;
  int unsigned m_k, m_n, m_step0;
  bit          m_match_prev, m_hit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int unsigned beep_step(input int unsigned s0, input int unsigned j);
    int unsigned s;
    s = s0;
`ifdef BEEP_SWEEP_EN
    for (int i = 0; i < int'(j); i++) begin
      s = s + (s >> 3);
      if (s > 255) s = 255;
    end
`else
    if (j > 1000) s = 0; // j unused when all beeps share one pitch
`endif
    return s;
  endfunction

  task automatic model_reset();
    m_active = 0; m_k = 0; m_n = 0; m_step0 = 0; m_match_prev = 0; m_hit = 0;
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_edge();
    bit start, match;
    start = bus.trig | m_hit;
    if (bus.cancel) begin
      m_active = 0;
    end else if (m_active) begin
      if (m_k == m_n * Per - GapC - 1) m_active = 0;
      else m_k++;
    end else if (start) begin
      m_active = 1;
      m_k      = 0;
      m_n      = (bus.beep_count == 0) ? 1 : int'(bus.beep_count);
      m_step0  = int'(bus.tone_step);
    end
    match        = bus.alarm_en && (bus.rtc_time == bus.alarm_time);
    m_hit        = match && !m_match_prev;
    m_match_prev = match;
  endtask

  task automatic check_outputs();
    int unsigned off, ph;
    bit          tone;
    off  = m_k % Per;
    ph   = (off * beep_step(m_step0, m_k / Per)) % 256;
    tone = m_active && (off < OnC) && (ph < int'(bus.duty));
    check("busy", 32'(bus.busy), 32'(m_active));
    check("buzzer_n", 32'(bus.buzzer_n), 32'(!tone));
    check("alarm_hit", 32'(bus.alarm_hit), 32'(m_hit));
  endtask

  // One clock: drive trig/cancel, let the edge happen, update model, compare.
  task automatic cyc(input logic t, input logic c);
    bus.trig   = t;
    bus.cancel = c;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  int hits;

  initial begin
    rst_n = 1'b0;
    bus.trig = 0; bus.cancel = 0; bus.alarm_en = 0;
    bus.alarm_time = 24'h073000; bus.rtc_time = 24'h072959;
    bus.beep_count = 4'd1; bus.tone_step = 8'd64; bus.duty = 8'd128;
    model_reset();
    #12;
    check_outputs();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single beep, then zero count behaves like one.
    cyc(1'b1, 1'b0); idle_cycles(14);
    bus.beep_count = 4'd0;
    cyc(1'b1, 1'b0); idle_cycles(14);

    // Triple burst; a trig during ON must not restart it.
    bus.beep_count = 4'd3;
    cyc(1'b1, 1'b0); idle_cycles(3);
    cyc(1'b1, 1'b0); idle_cycles(42);

    // Cancel in the middle of the first gap.
    cyc(1'b1, 1'b0); idle_cycles(12);
    cyc(1'b0, 1'b1); idle_cycles(3);

    // trig together with cancel while idle stays idle.
    cyc(1'b1, 1'b1); idle_cycles(3);

    // Sweep-sensitive burst: step 64 with a duty that separates 64/72/81.
    bus.duty = 8'd150;
    cyc(1'b1, 1'b0); idle_cycles(44);

    // Alarm: match held 50 cycles gives exactly one hit.
    bus.beep_count = 4'd2; bus.duty = 8'd128;
    bus.alarm_en = 1'b1;
    idle_cycles(3);
    bus.rtc_time = 24'h073000;
    hits = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1'b0, 1'b0);
      if (bus.alarm_hit) hits++;
    end
    check("alarm_hit_count", 32'(hits), 32'd1);
    bus.rtc_time = 24'h073001; idle_cycles(3);
    bus.alarm_en = 1'b0;
    bus.rtc_time = 24'h073000; idle_cycles(5);
    bus.rtc_time = 24'h073001; idle_cycles(3);

    // Reset mid-ON: outputs return to reset values without a clock edge.
    bus.beep_count = 4'd2;
    cyc(1'b1, 1'b0); idle_cycles(3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_buzzer_n", 32'(bus.buzzer_n), 32'd1);
    check("rst_alarm_hit", 32'(bus.alarm_hit), 32'd0);
    #3 rst_n = 1'b1;
    idle_cycles(2);

    // Randomized traffic; tone settings only change while idle.
    for (int i = 0; i < 1500; i++) begin
      if (!m_active && ($urandom % 6 == 0)) begin
        bus.beep_count = 4'($urandom_range(4));
        bus.tone_step  = 8'($urandom_range(255));
        bus.duty       = 8'($urandom_range(255));
      end
      if ($urandom % 60 == 0) bus.alarm_en = ~bus.alarm_en;
      if ($urandom % 25 == 0) bus.rtc_time = ($urandom % 2 == 0) ? 24'h073000 : 24'h120000;
      cyc(1'(($urandom % 20) == 0), 1'(($urandom % 90) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
